// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/issue side of the single-cycle CPU.
// Instruction fields: [15:14] type, [13:10] signed branch offset,
// [9:6] src1, [5:2] src2, [1:0] branch function.
package cpu_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    S_LOAD  = 2'b00,
    S_READY = 2'b01,
    S_RUN   = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  // Instruction type codes (instr[15:14])
  localparam logic [1:0] TYPE_ALU  = 2'b00;
  localparam logic [1:0] TYPE_MOVI = 2'b01;
  localparam logic [1:0] TYPE_BR   = 2'b10;
  localparam logic [1:0] TYPE_HALT = 2'b11;

  // Branch function codes (instr[1:0]); 2'b1x is a never-taken branch
  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_NE = 2'b01;

  // Resolve a branch from its function code and the source-equality result
  function automatic logic branch_taken(input logic [1:0] func, input logic eq);
    logic taken;
    case (func)
      BR_EQ:   taken = eq;
      BR_NE:   taken = !eq;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Program memory: 16-bit words, synchronous write, asynchronous read.
// The array is deliberately not reset so a program survives rst_n.
module instr_mem #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [15:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [15:0]       o_rdata
);

  logic [15:0] r_mem [2**ADDR_W];

  // Store one program word per accepted load beat
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: loads a program over a valid/ready port, then issues one
// instruction per cycle from PC 0 until HALT, resolving BEQ/BNE from the
// datapath's source register values.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [15:0]       load_data,
  input  logic              load_last,
  input  logic              start,
  input  logic              reload,
  input  logic [WIDTH-1:0]  rs_data1,
  input  logic [WIDTH-1:0]  rs_data2,
  output logic [15:0]       instruction,
  output logic              write_en,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              halted,
  output logic [15:0]       retired
);

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] r_load_ptr;
  logic [ADDR_W-1:0] w_next_ptr;
  logic [15:0]       r_retired;
  logic [15:0]       w_next_retired;
  logic [15:0]       w_rdata;
  logic              w_accept;
  logic [1:0]        w_type;
  logic [1:0]        w_func;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_pc_seq;
  logic              w_eq;

  instr_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_load_ptr),
    .i_wdata (load_data),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  assign w_accept = load_valid && (r_state == S_LOAD);
  assign w_type   = w_rdata[15:14];
  assign w_func   = w_rdata[1:0];
  assign w_offset = {{(ADDR_W-4){w_rdata[13]}}, w_rdata[13:10]};
  assign w_pc_seq = r_pc + ADDR_ONE;
  assign w_eq     = (rs_data1 == rs_data2);

  // Next-state, next-pc/pointer/counter and issue decode
  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = r_pc;
    w_next_ptr     = r_load_ptr;
    w_next_retired = r_retired;
    instruction    = 16'h0000;
    write_en       = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (load_last || (r_load_ptr == PTR_LAST)) begin
            w_next_state = S_READY;
          end else begin
            w_next_ptr = r_load_ptr + ADDR_ONE;
          end
        end else begin
          w_next_state = S_LOAD;
        end
      end
      S_READY, S_HALT: begin
        if (reload) begin
          w_next_state = S_LOAD;
          w_next_ptr   = ADDR_ZERO;
        end else if (start) begin
          w_next_state   = S_RUN;
          w_next_pc      = ADDR_ZERO;
          w_next_retired = 16'h0000;
        end else begin
          w_next_state = r_state;
        end
      end
      S_RUN: begin
        instruction = w_rdata;
        write_en    = (w_type == TYPE_ALU) || (w_type == TYPE_MOVI);
        if (w_type == TYPE_HALT) begin
          w_next_state = S_HALT;
        end else begin
          w_next_retired = (r_retired == 16'hFFFF) ? r_retired : r_retired + 16'h0001;
          if ((w_type == TYPE_BR) && branch_taken(w_func, w_eq)) begin
            w_next_pc = w_pc_seq + w_offset;
          end else begin
            w_next_pc = w_pc_seq;
          end
        end
      end
      default: begin
        w_next_state = S_LOAD;
      end
    endcase
  end

  // Architectural state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LOAD;
      r_pc       <= ADDR_ZERO;
      r_load_ptr <= ADDR_ZERO;
      r_retired  <= 16'h0000;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_load_ptr <= w_next_ptr;
      r_retired  <= w_next_retired;
    end
  end

  assign load_ready = (r_state == S_LOAD);
  assign running    = (r_state == S_RUN);
  assign halted     = (r_state == S_HALT);
  assign pc         = r_pc;
  assign retired    = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. The bench plays the datapath by driving
// rs_data1/rs_data2 directly. Inputs change and outputs are sampled 1ns after
// each rising edge.
module tb_fetch_sequencer;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_valid;
  logic              load_ready;
  logic [15:0]       load_data;
  logic              load_last;
  logic              start;
  logic              reload;
  logic [WIDTH-1:0]  rs_data1;
  logic [WIDTH-1:0]  rs_data2;
  logic [15:0]       instruction;
  logic              write_en;
  logic [ADDR_W-1:0] pc;
  logic              running;
  logic              halted;
  logic [15:0]       retired;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .start(start), .reload(reload),
    .rs_data1(rs_data1), .rs_data2(rs_data2), .instruction(instruction),
    .write_en(write_en), .pc(pc), .running(running), .halted(halted), .retired(retired)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic l);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = l;
    step();
  endtask

  task automatic end_load();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // MOVI r1,5 / MOVI r2,5 / BEQ r1,r2,+2 / filler / filler / HALT
  task automatic load_beq_prog(input logic [15:0] br_word);
    beat(16'h4414, 1'b0);
    beat(16'h4814, 1'b0);
    beat(br_word, 1'b0);
    beat(16'h0000, 1'b0);
    beat(16'h0000, 1'b0);
    beat(16'hC000, 1'b1);
    end_load();
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = 16'h0000; load_last = 1'b0;
    start = 1'b0; reload = 1'b0; rs_data1 = 8'h00; rs_data2 = 8'h00;

    // 1. Reset values
    #2;
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_instr", 32'(instruction), 32'h0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    #1 rst_n = 1'b1;

    // Three-word load with valid held, last on the third
    beat(16'h1111, 1'b0);
    beat(16'h2222, 1'b0);
    chk("load3_ready_mid", 32'(load_ready), 32'd1);
    beat(16'h3333, 1'b1);
    end_load();
    chk("load3_ready_done", 32'(load_ready), 32'd0);
    chk("load3_not_running", 32'(running), 32'd0);
    start = 1'b0;

    // 4b. Full memory without load_last; word 59 is HALT for the wrap test
    do_reload();
    chk("reload_ready", 32'(load_ready), 32'd1);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk("full_ready_before_last", 32'(load_ready), 32'd1);
      beat((i == 59) ? 16'hC000 : 16'h0000, 1'b0);
    end
    chk("full_exit", 32'(load_ready), 32'd0);
    load_last = 1'b1;
    step();
    step();
    chk("full_extra_ignored", 32'(load_ready), 32'd0);
    chk("full_extra_not_run", 32'(running), 32'd0);
    end_load();

    // 2. BEQ taken: pc 0,1,2,5
    do_reload();
    load_beq_prog(16'h8848);
    rs_data1 = 8'd5; rs_data2 = 8'd5;
    do_start();
    chk("beq_pc0", 32'(pc), 32'd0);
    chk("beq_we0", 32'(write_en), 32'd1);
    chk("beq_run", 32'(running), 32'd1);
    step();
    chk("beq_pc1", 32'(pc), 32'd1);
    chk("beq_we1", 32'(write_en), 32'd1);
    step();
    chk("beq_pc2", 32'(pc), 32'd2);
    chk("beq_we2", 32'(write_en), 32'd0);
    chk("beq_instr2", 32'(instruction), 32'h8848);
    step();
    chk("beq_pc5", 32'(pc), 32'd5);
    chk("beq_we5", 32'(write_en), 32'd0);
    step();
    chk("beq_halted", 32'(halted), 32'd1);
    chk("beq_pc_hold", 32'(pc), 32'd5);
    chk("beq_retired", 32'(retired), 32'd3);
    chk("beq_instr_idle", 32'(instruction), 32'h0);

    // 3. BNE not taken with equal sources: pc 0..5
    do_reload();
    load_beq_prog(16'h8849);
    do_start();
    for (int i = 0; i < 6; i++) begin
      chk("bne_pc", 32'(pc), 32'(i));
      chk("bne_we", 32'(write_en), (i == 2 || i == 5) ? 32'd0 : 32'd1);
      step();
    end
    chk("bne_halted", 32'(halted), 32'd1);
    chk("bne_retired", 32'(retired), 32'd5);

    // 3b. Taken BEQ with offset -8 at pc 2 wraps to 59
    do_reload();
    beat(16'h4414, 1'b0);
    beat(16'h4814, 1'b0);
    beat(16'hA048, 1'b1);
    end_load();
    do_start();
    step();
    step();
    chk("neg_pc2", 32'(pc), 32'd2);
    step();
    chk("neg_pc59", 32'(pc), 32'd59);
    chk("neg_instr59", 32'(instruction), 32'hC000);
    step();
    chk("neg_halted", 32'(halted), 32'd1);
    chk("neg_retired", 32'(retired), 32'd3);

    // 4a. Backpressure: only valid beats are written
    do_reload();
    load_valid = 1'b0; load_data = 16'hDEAD; load_last = 1'b0; step();
    beat(16'h4414, 1'b0);
    load_valid = 1'b0; load_data = 16'hBEEF; load_last = 1'b1; step();
    load_valid = 1'b0; load_data = 16'hDEAD; load_last = 1'b0; step();
    chk("bp_still_loading", 32'(load_ready), 32'd1);
    beat(16'h0123, 1'b0);
    beat(16'hC000, 1'b1);
    end_load();
    chk("bp_done", 32'(load_ready), 32'd0);
    do_start();
    chk("bp_w0", 32'(instruction), 32'h4414);
    step();
    chk("bp_w1", 32'(instruction), 32'h0123);
    step();
    chk("bp_w2", 32'(instruction), 32'hC000);
    step();
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_retired", 32'(retired), 32'd2);

    // 5. start and reload together in S_HALT: reload wins
    start = 1'b1; reload = 1'b1;
    step();
    start = 1'b0; reload = 1'b0;
    chk("conflict_load", 32'(load_ready), 32'd1);
    chk("conflict_not_run", 32'(running), 32'd0);
    load_beq_prog(16'h8848);
    do_start();
    step();
    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("run_reload_pc2", 32'(pc), 32'd2);
    chk("run_reload_running", 32'(running), 32'd1);
    step();
    chk("run_reload_pc5", 32'(pc), 32'd5);
    step();
    chk("run_reload_halted", 32'(halted), 32'd1);

    // Reset mid-run, then reload word 0 and rerun the retained program
    do_start();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_load_ready", 32'(load_ready), 32'd1);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_retired", 32'(retired), 32'd0);
    chk("midrst_instr", 32'(instruction), 32'h0);
    #1 rst_n = 1'b1;
    beat(16'h4414, 1'b1);
    end_load();
    do_start();
    step();
    step();
    chk("rerun_instr2", 32'(instruction), 32'h8848);
    step();
    chk("rerun_pc5", 32'(pc), 32'd5);
    step();
    chk("rerun_halted", 32'(halted), 32'd1);
    chk("rerun_retired", 32'(retired), 32'd3);

    // 6. Tight loop BEQ r0,r0,-1 saturates retired
    do_reload();
    beat(16'hBC00, 1'b1);
    end_load();
    rs_data1 = 8'd0; rs_data2 = 8'd0;
    do_start();
    chk("loop_instr", 32'(instruction), 32'hBC00);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_retired", 32'(retired), 32'hFFFF);
    chk("sat_pc", 32'(pc), 32'd0);
    chk("sat_running", 32'(running), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("sat_rst_retired", 32'(retired), 32'd0);
    chk("sat_rst_ready", 32'(load_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
